// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and helpers for the scoreboarded register
//                file (default geometry, hard-wired zero register, flat-vector
//                lane extraction).
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int ZERO_REG = 0;

   // Upper bounds for the generic lane extractor below.
   localparam int FLAT_MAX = 256;
   localparam int LANE_MAX = 64;

   // Return lane k (w bits wide) of a flat packed vector, zero-extended.
   function automatic logic [LANE_MAX-1:0] get_lane(
      input logic [FLAT_MAX-1:0] flat,
      input int                  k,
      input int                  w
   );
      logic [LANE_MAX-1:0] r;
      logic [7:0]          idx;
      r = '0;
      for (int i = 0; i < LANE_MAX; i++) begin
         idx = 8'(k * w + i);
         if ((i < w) && ((k * w + i) < FLAT_MAX)) begin
            r[6'(i)] = flat[idx];
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register busy bits. Set at issue, cleared at writeback,
//                bulk-cleared on flush; combinational per-port busy lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREG   = NREG_DEF,
   parameter int AW     = $clog2(NREG),
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [AW-1:0]     i_a3,
   input  logic              i_issue_en,
   input  logic [AW-1:0]     i_issue_rd,
   input  logic              i_flush,
   input  logic [NRD*AW-1:0] i_ra,
   output logic [NRD-1:0]    o_rbusy
);

   localparam logic [AW-1:0] c_zero = AW'(ZERO_REG);

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;

   // Next busy state: flush dominates; otherwise writeback clear then issue set.
   always_comb begin
      w_busy_nxt = r_busy;
      if (i_flush) begin
         w_busy_nxt = '0;
      end else begin
         if (i_we && (i_a3 != c_zero)) begin
            w_busy_nxt[i_a3] = 1'b0;
         end
         if (i_issue_en && (i_issue_rd != c_zero)) begin
            w_busy_nxt[i_issue_rd] = 1'b1;
         end
      end
      w_busy_nxt[ZERO_REG] = 1'b0;
   end

   // Busy vector register, asynchronously cleared by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_port
      logic [AW-1:0] w_ra;
      logic          w_byp_hit;

      assign w_ra      = AW'(get_lane(FLAT_MAX'(i_ra), k, AW));
      // Data arriving on the write port this cycle is already usable via bypass.
      assign w_byp_hit = (BYPASS != 0) && rst && i_we && (i_a3 == w_ra);
      assign o_rbusy[k] = (w_ra != c_zero) && r_busy[w_ra] && !w_byp_hit;
   end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Parametrised integer register file with optional
//                write-to-read bypass and a per-register busy scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int NRD    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                WE,
   input  logic [AW-1:0]       A3,
   input  logic [XLEN-1:0]     WD,
   input  logic [NRD*AW-1:0]   RA,
   output logic [NRD*XLEN-1:0] RD,
   output logic [NRD-1:0]      RBUSY,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_rd,
   input  logic                flush
);

   localparam logic [AW-1:0] c_zero = AW'(ZERO_REG);

   logic [XLEN-1:0] r_regs [NREG];

   // Register storage; address 0 is never written so it stays zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (WE && (A3 != c_zero)) begin
         r_regs[A3] <= WD;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   w_ra;
      logic            w_byp_hit;
      logic [XLEN-1:0] w_rd;

      assign w_ra      = AW'(get_lane(FLAT_MAX'(RA), k, AW));
      // Bypass is held off during reset so outputs read zero while reset is low.
      assign w_byp_hit = (BYPASS != 0) && rst && WE && (A3 == w_ra);

      // Read mux: zero register, then forwarded writeback data, then storage.
      always_comb begin
         w_rd = r_regs[w_ra];
         if (w_ra == c_zero) begin
            w_rd = '0;
         end else if (w_byp_hit) begin
            w_rd = WD;
         end
      end

      assign RD[k*XLEN +: XLEN] = w_rd;
   end

   regfile_scoreboard #(
      .NREG   (NREG),
      .AW     (AW),
      .NRD    (NRD),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .i_we       (WE),
      .i_a3       (A3),
      .i_issue_en (issue_en),
      .i_issue_rd (issue_rd),
      .i_flush    (flush),
      .i_ra       (RA),
      .o_rbusy    (RBUSY)
   );

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Self-checking bench for regfile_sb, bypass and no-bypass
//                builds driven side by side from the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int NRD  = 2;

   logic                clk      = 1'b0;
   logic                rst      = 1'b0;
   logic                WE       = 1'b0;
   logic [AW-1:0]       A3       = '0;
   logic [XLEN-1:0]     WD       = '0;
   logic [NRD*AW-1:0]   RA       = '0;
   logic                issue_en = 1'b0;
   logic [AW-1:0]       issue_rd = '0;
   logic                flush    = 1'b0;

   logic [NRD*XLEN-1:0] rd1, rd0;
   logic [NRD-1:0]      rb1, rb0;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut1 (
      .clk(clk), .rst(rst), .WE(WE), .A3(A3), .WD(WD), .RA(RA), .RD(rd1),
      .RBUSY(rb1), .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush)
   );

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut0 (
      .clk(clk), .rst(rst), .WE(WE), .A3(A3), .WD(WD), .RA(RA), .RD(rd0),
      .RBUSY(rb0), .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush)
   );

   // ---------------- reference model ----------------
   logic [XLEN-1:0] m_reg  [NREG];
   logic            m_busy [NREG];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            m_reg[i]  <= '0;
            m_busy[i] <= 1'b0;
         end
      end else begin
         if (WE && A3 != 0) m_reg[A3] <= WD;
         for (int i = 0; i < NREG; i++) begin
            if (flush)
               m_busy[i] <= 1'b0;
            else
               m_busy[i] <= (i != 0) &&
                            ((issue_en && int'(issue_rd) == i) ||
                             (m_busy[i] && !(WE && int'(A3) == i)));
         end
      end
   end

   function automatic logic [XLEN-1:0] exp_rd(int k, bit byp);
      logic [AW-1:0] a;
      a = RA[k*AW +: AW];
      if (!rst || a == 0) return '0;
      if (byp && WE && A3 == a) return WD;
      return m_reg[a];
   endfunction

   function automatic logic exp_rbusy(int k, bit byp);
      logic [AW-1:0] a;
      a = RA[k*AW +: AW];
      if (!rst || a == 0) return 1'b0;
      if (byp && WE && A3 == a) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare both builds against the model in the middle of every cycle.
   always @(negedge clk) begin
      for (int k = 0; k < NRD; k++) begin
         chk("model_rd_bypass",   64'(rd1[k*XLEN +: XLEN]), 64'(exp_rd(k, 1'b1)));
         chk("model_rd_nobypass", 64'(rd0[k*XLEN +: XLEN]), 64'(exp_rd(k, 1'b0)));
         chk("model_rbusy_bypass",   64'(rb1[k]), 64'(exp_rbusy(k, 1'b1)));
         chk("model_rbusy_nobypass", 64'(rb0[k]), 64'(exp_rbusy(k, 1'b0)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      WE = 1'b0; issue_en = 1'b0; flush = 1'b0;
      A3 = '0; issue_rd = '0; WD = '0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      repeat (3) tick();
      RA = {5'd31, 5'd5};
      #1;
      chk("in_reset_rd", 64'(rd1), 64'd0);
      rst = 1'b1;
      #1;
      chk("after_reset_rd", 64'(rd1), 64'd0);
      chk("after_reset_rbusy", 64'(rb1), 64'd0);

      // Write with same-cycle read
      tick();
      WE = 1'b1; A3 = 5'd5; WD = 32'hDEADBEEF;
      #1;
      chk("bypass_same_cycle", 64'(rd1[31:0]), 64'hDEADBEEF);
      chk("nobypass_same_cycle", 64'(rd0[31:0]), 64'd0);
      tick();
      idle();
      #1;
      chk("bypass_next_cycle", 64'(rd1[31:0]), 64'hDEADBEEF);
      chk("nobypass_next_cycle", 64'(rd0[31:0]), 64'hDEADBEEF);

      // Register 0 protection
      tick();
      WE = 1'b1; A3 = 5'd0; WD = 32'h12345678; issue_en = 1'b1; issue_rd = 5'd0;
      RA = {5'd0, 5'd0};
      #1;
      chk("x0_rd_same", 64'(rd1), 64'd0);
      chk("x0_rbusy_same", 64'(rb1), 64'd0);
      tick();
      idle();
      #1;
      chk("x0_rd_after", 64'(rd1), 64'd0);
      chk("x0_rbusy_after", 64'(rb1), 64'd0);

      // Scoreboard set / simultaneous clear+set / clear
      issue_en = 1'b1; issue_rd = 5'd7;
      tick();
      idle();
      RA = {5'd0, 5'd7};
      #1;
      chk("busy7_set", 64'(rb1[0]), 64'd1);
      WE = 1'b1; A3 = 5'd7; WD = 32'h77; issue_en = 1'b1; issue_rd = 5'd7;
      #1;
      chk("busy7_bypass_masked", 64'(rb1[0]), 64'd0);
      chk("busy7_nobypass_visible", 64'(rb0[0]), 64'd1);
      tick();
      idle();
      #1;
      chk("busy7_set_wins", 64'(rb1[0]), 64'd1);
      WE = 1'b1; A3 = 5'd7; WD = 32'h78;
      tick();
      idle();
      #1;
      chk("busy7_cleared", 64'(rb1[0]), 64'd0);
      chk("reg7_value", 64'(rd0[31:0]), 64'h78);

      // Flush with concurrent writeback
      issue_en = 1'b1; issue_rd = 5'd3;  tick();
      issue_rd = 5'd9;                   tick();
      issue_rd = 5'd12;                  tick();
      idle();
      RA = {5'd9, 5'd3};
      #1;
      chk("busy_3_9", 64'(rb0), 64'b11);
      flush = 1'b1; WE = 1'b1; A3 = 5'd3; WD = 32'h55;
      tick();
      idle();
      RA = {5'd12, 5'd3};
      #1;
      chk("flush_rbusy", 64'(rb1), 64'd0);
      chk("flush_rbusy_nobyp", 64'(rb0), 64'd0);
      chk("flush_reg3", 64'(rd0[31:0]), 64'h55);

      // Asynchronous reset mid-cycle
      WE = 1'b1; A3 = 5'd4; WD = 32'hAA;
      tick();
      idle();
      RA = {5'd4, 5'd4};
      #1;
      chk("reg4_value", 64'(rd0[31:0]), 64'hAA);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset_rd", 64'(rd1), 64'd0);
      chk("async_reset_rd_nobyp", 64'(rd0), 64'd0);
      tick();
      rst = 1'b1;

      // Rolling write-behind-issue pattern
      for (int i = 1; i <= 8; i++) begin
         WE = 1'b1; A3 = 5'(i); WD = 32'h01010101 * 32'(i);
         issue_en = 1'b1; issue_rd = 5'(i + 1);
         RA = {5'(i + 1), 5'(i)};
         tick();
      end
      idle();
      RA = {5'd9, 5'd8};
      #1;
      chk("roll_reg8", 64'(rd1[31:0]), 64'h08080808);
      chk("roll_busy9", 64'(rb1[1]), 64'd1);
      RA = {5'd2, 5'd5};
      #1;
      chk("roll_reg5", 64'(rd0[31:0]), 64'h05050505);
      chk("roll_busy2_clear", 64'(rb0[1]), 64'd0);
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-issue integer register file.
- Adds the following over the fixed 32x32, two-read-port design:
  - configurable register width, register depth and read-port count;
  - optional write-to-read bypass;
  - per-register busy scoreboard for the pipelined core (set at issue, cleared at writeback, bulk-cleared on flush).
- Sits between decode/issue (read ports, busy query, issue) and writeback (write port) of the core.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers. Power of two, >= 2. Register 0 is hard-wired zero.
- AW, $clog2(NREG), register address width. Derived; not overridden.
- NRD, 2, number of read ports. Range 1..4.
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- WE  input  1  writeback write enable.
- A3  input  AW  writeback destination address.
- WD  input  XLEN  writeback data.
- RA  input  NRD*AW  read addresses; port k at bits [k*AW +: AW].
- RD  output  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN].
- RBUSY  output  NRD  port k busy flag: register at RA[k] has an outstanding writer.
- issue_en  input  1  instruction issued this cycle with a destination register.
- issue_rd  input  AW  destination register of the issuing instruction.
- flush  input  1  synchronous clear of all busy bits (pipeline flush).

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers <= 0; all busy bits <= 0.
  - Consequently RD = 0 and RBUSY = 0 for every port while in reset.
  - Reset asserted mid-operation discards pending writes and issues immediately.
- Write:
  - on rising clk, if WE && A3 != 0 then reg[A3] <= WD.
  - Writes to address 0 are dropped.
  - Storage latency: 1 cycle.
- Read (combinational), for each port k:
  - if RA[k] == 0 then RD[k] = 0;
  - else if BYPASS && WE && A3 == RA[k] then RD[k] = WD;
  - else RD[k] = reg[RA[k]].
  - Several ports reading the same address all receive the same value.
- Busy scoreboard: NREG bits; bit 0 constant 0. On rising clk, evaluated in this order:
  - flush = 1: all busy <= 0. issue_en and the WE clear are both ignored that cycle; register write still occurs.
  - else:
    - WE && A3 != 0 clears busy[A3];
    - then issue_en && issue_rd != 0 sets busy[issue_rd].
    - Same address in both: set wins (the newer writer is outstanding).
- RBUSY[k], combinational:
  - = busy[RA[k]], except forced 0 when BYPASS && WE && A3 == RA[k] (data available via bypass).
  - RA[k] == 0 always gives RBUSY[k] = 0.
- Boundaries:
  - Address wrap: none. Addresses are exactly AW bits and all NREG locations are valid.
  - Issue to an already-busy register: stays busy (no counting). One outstanding writer per register is guaranteed by the issue logic.
  - WE to a non-busy register is legal; it writes data and leaves busy at 0.
  - Simultaneous flush and WE: data written, busy cleared globally.

Decomposition:
- Shared package regfile_pkg:
  - default constants XLEN_DEF=32, NREG_DEF=32;
  - localparam ZERO_REG=0;
  - function to extract lane k from a flat vector.
- One sub-module is natural: regfile_scoreboard, holding the busy vector with set/clear/flush logic and the per-port busy lookup.
- Storage array and read muxes stay in regfile_sb.

Test Plan:
- Reset then read: rst=0 then 1. Read RA={5,31} -> RD={0,0}, RBUSY=00.
- Write/read with BYPASS=1: WE=1, A3=5, WD=0xDEADBEEF, RA[0]=5 in the same cycle -> RD[0]=0xDEADBEEF combinationally. Next cycle with WE=0 -> still 0xDEADBEEF.
- Write/read with BYPASS=0: same stimulus -> RD[0]=0 that cycle, 0xDEADBEEF the next.
- x0 protection: WE=1, A3=0, WD=0x12345678; issue_en=1, issue_rd=0 -> RD for RA=0 is 0 and RBUSY=0, both in the same cycle and after.
- Scoreboard: issue_en=1, issue_rd=7 -> next cycle RBUSY=1 for RA=7.
  - Then WE=1, A3=7, issue_en=1, issue_rd=7 in the same cycle -> RBUSY=0 during that cycle (BYPASS=1), busy[7]=1 after.
  - Then WE=1, A3=7 alone -> busy[7]=0.
- Flush and async reset: set busy on 3, 9, 12. flush=1 with WE=1, A3=3, WD=0x55 -> all RBUSY 0 and reg3=0x55.
  - Then write reg4=0xAA and pull rst low mid-cycle -> RD for RA=4 drops to 0 immediately, without waiting for a clk edge.
